subtractor_32bits_seq: RTL and testbench

- Multi-cycle 32-bit subtractor with borrow-in. Computes d = a - b - bi one 4-bit digit per clock, least-significant digit first.
- Provides unsigned borrow-out, signed overflow and zero flags.
- Companion to the combinational 32-bit adders in the datapath. Used where area matters more than latency, for example in compare/decrement paths of sequential control units.
- Valid/ready handshake on both input and output.

---
 rtl/subtractor_32bits_seq.sv | 101 ++++++++++
 tb/tb_subtractor_32bits_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/subtractor_32bits_seq.sv
// Multi-cycle subtractor: d = a - b - bi, one DIGIT-wide slice per clock, LSB digit first.
// Valid/ready handshake on operands and result; flags are registered on the final digit.
module subtractor_32bits_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state, w_next;
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  r_a, r_b, r_d;
  logic              r_br, r_bo, r_ovf, r_zero;

  int unsigned       w_lsb;
  logic [DIGIT:0]    w_diff;
  logic [WIDTH-1:0]  w_d_next;
  logic              w_last;

  // Extra top bit of w_diff is the digit's borrow-out (result went negative).
  always_comb begin
    w_lsb    = 32'(r_step) * DIGIT;
    w_diff   = {1'b0, r_a[w_lsb +: DIGIT]} - {1'b0, r_b[w_lsb +: DIGIT]}
             - {{DIGIT{1'b0}}, r_br};
    w_d_next = r_d;
    w_d_next[w_lsb +: DIGIT] = w_diff[DIGIT-1:0];
    w_last   = (r_step == STEP_W'(STEPS - 1));
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bo    <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bi;
            r_step <= '0;
          end
        end
        RUN: begin
          r_d    <= w_d_next;
          r_br   <= w_diff[DIGIT];
          r_step <= r_step + 1'b1;
          if (w_last) begin
            r_bo   <= w_diff[DIGIT];
            r_zero <= (w_d_next == '0);
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign d         = r_d;
  assign bo        = r_bo;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_subtractor_32bits_seq.sv
// Directed-vector bench for subtractor_32bits_seq: arithmetic, latency, handshake,
// backpressure and asynchronous reset during an operation.
module tb_subtractor_32bits_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bi = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        bo, ovf, zero;

  int total = 0;
  int bad   = 0;

  subtractor_32bits_seq #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bo(bo), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Present operands for one accept edge, then scramble them to prove they were latched.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbi);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; bi = ~tbi;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic accept_result;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({d, bo, ovf, zero} !== 35'd0) begin bad++; $display("FAIL reset_outputs d=%h bo=%b ovf=%b zero=%b exp all 0", d, bo, ovf, zero); end
  endtask

  task automatic test_arith;
    logic [31:0] va [9] = '{32'h5, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h00010000,
                            32'h5, 32'h5, 32'h0, 32'h80000000};
    logic [31:0] vb [9] = '{32'h3, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h1,
                            32'h4, 32'h5, 32'h0, 32'h80000000};
    logic        vi [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] vd [9] = '{32'h2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF,
                            32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [2:0]  vf [9] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b000,
                            3'b001, 3'b100, 3'b100, 3'b001};  // {bo, ovf, zero}
    int lat;
    for (int i = 0; i < 9; i++) begin
      start_op(va[i], vb[i], vi[i]);
      wait_done(lat);
      total++; if (lat != 8) begin bad++; $display("FAIL arith%0d_latency got=%0d exp=8", i, lat); end
      total++; if (d !== vd[i]) begin bad++; $display("FAIL arith%0d_d got=%h exp=%h", i, d, vd[i]); end
      total++; if ({bo, ovf, zero} !== vf[i]) begin bad++; $display("FAIL arith%0d_flags got=%b exp=%b", i, {bo, ovf, zero}, vf[i]); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arith%0d_in_ready_done got=%b exp=0", i, in_ready); end
      accept_result();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arith%0d_release out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready); end
      total++; if (d !== vd[i]) begin bad++; $display("FAIL arith%0d_hold_d got=%h exp=%h", i, d, vd[i]); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(32'h00000100, 32'h00000001, 1'b0);
    wait_done(lat);
    @(negedge clk); in_valid = 1'b1; a = 32'h0; b = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 32'h000000FF || {bo, ovf, zero} !== 3'b000) begin
        bad++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b d=%h flags=%b exp 1/0/000000ff/000", c, out_valid, in_ready, d, {bo, ovf, zero});
      end
    end
    in_valid = 1'b0;
    accept_result();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    start_op(32'hFFFFFFFF, 32'h00000000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (d[15:0] !== 16'hFFFF || out_valid !== 1'b0) begin bad++; $display("FAIL midrun_partial d=%h out_valid=%b exp low 16 bits ffff, 0", d, out_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({d, bo, ovf, zero} !== 35'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_reset d=%h flags=%b out_valid=%b in_ready=%b exp 0/000/0/1", d, {bo, ovf, zero}, out_valid, in_ready);
    end
    repeat (10) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_no_partial got=%b exp=0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    start_op(32'h12345678, 32'h02345678, 1'b0);
    wait_done(lat);
    total++; if (lat != 8) begin bad++; $display("FAIL post_reset_latency got=%0d exp=8", lat); end
    total++; if (d !== 32'h10000000 || {bo, ovf, zero} !== 3'b000) begin bad++; $display("FAIL post_reset_result d=%h flags=%b exp 10000000/000", d, {bo, ovf, zero}); end
    accept_result();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
